// File: rtl/qmca_clk_monitor_pkg.sv
// Shared types and helpers for the generated-clock monitor.
package qmca_clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_e;

  localparam int unsigned GATE_CYCLES_DEF = 4800;
  localparam int unsigned TOL_DEF         = 8;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/qmca_clk_monitor_if.sv
// Register-bank side of the clock monitor: expected counts and CLEAR in, results out.
interface qmca_clk_monitor_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic [NCH*CNT_W-1:0] EXP_COUNT;
  logic                 CLEAR;
  logic [NCH*CNT_W-1:0] FREQ_COUNT;
  logic [NCH-1:0]       FREQ_OK;
  logic                 VALID;
  logic                 LOCK_LOST;
  logic [7:0]           LOCK_LOSS_CNT;

  modport master (
    output EXP_COUNT, CLEAR,
    input  FREQ_COUNT, FREQ_OK, VALID, LOCK_LOST, LOCK_LOSS_CNT
  );

  modport slave (
    input  EXP_COUNT, CLEAR,
    output FREQ_COUNT, FREQ_OK, VALID, LOCK_LOST, LOCK_LOSS_CNT
  );
endinterface

// File: rtl/qmca_edge_counter.sv
// One monitored clock: 2-FF synchroniser, rising-edge detect and saturating edge counter.
module qmca_edge_counter
  import qmca_clk_monitor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk_i,
  input  logic             clr_i,
  input  logic             reload_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             edge_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= mon_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      count_q <= count_d;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

  // Reload keeps an edge that arrives in the latch cycle for the next window.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (reload_i) begin
      count_d    = '0;
      count_d[0] = edge_o;
    end else if (en_i && edge_o) begin
      count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/qmca_clk_monitor.sv
// Gated edge counting of NCH generated clocks against expected values, plus LOCKED loss tracking.
module qmca_clk_monitor
  import qmca_clk_monitor_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int TOL         = TOL_DEF
) (
  input  logic           BUS_CLK,
  input  logic           BUS_RST_N,
  input  logic [NCH-1:0] MON_CLK,
  input  logic           LOCKED,
  qmca_clk_monitor_if.slave bus
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  function automatic logic in_tol(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] exp_c);
    logic signed [CNT_W:0] diff, mag;
    diff = $signed({1'b0, cnt}) - $signed({1'b0, exp_c});
    mag  = (diff < 0) ? -diff : diff;
    return $unsigned(mag) <= (CNT_W+1)'(TOL);
  endfunction

  state_e               state_q, state_d;
  logic [GATE_W-1:0]    gate_q, gate_d;
  logic                 lk_s1_q, lk_s2_q, lk_prev_q;
  logic                 lock_fall;
  logic                 cnt_clr, cnt_reload, cnt_en, latch_now;
  logic [NCH*CNT_W-1:0] counts;
  logic [NCH-1:0]       ok_now;
  // Edge pulses are available per channel but the top only needs the counts.
  logic [NCH-1:0]       mon_edge_unused;

  logic [NCH*CNT_W-1:0] freq_count_q, freq_count_d;
  logic [NCH-1:0]       freq_ok_q, freq_ok_d;
  logic                 valid_q, valid_d;
  logic                 lost_q, lost_d;
  logic [7:0]           loss_cnt_q, loss_cnt_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    qmca_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (BUS_CLK),
      .rst_n    (BUS_RST_N),
      .mon_clk_i(MON_CLK[i]),
      .clr_i    (cnt_clr),
      .reload_i (cnt_reload),
      .en_i     (cnt_en),
      .count_o  (counts[i*CNT_W +: CNT_W]),
      .edge_o   (mon_edge_unused[i])
    );
    assign ok_now[i] = in_tol(counts[i*CNT_W +: CNT_W], bus.EXP_COUNT[i*CNT_W +: CNT_W]);
  end

  assign lock_fall = lk_prev_q & ~lk_s2_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q      <= IDLE;
      gate_q       <= '0;
      lk_s1_q      <= 1'b0;
      lk_s2_q      <= 1'b0;
      lk_prev_q    <= 1'b0;
      freq_count_q <= '0;
      freq_ok_q    <= '0;
      valid_q      <= 1'b0;
      lost_q       <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      lk_s1_q      <= LOCKED;
      lk_s2_q      <= lk_s1_q;
      lk_prev_q    <= lk_s2_q;
      freq_count_q <= freq_count_d;
      freq_ok_q    <= freq_ok_d;
      valid_q      <= valid_d;
      lost_q       <= lost_d;
      loss_cnt_q   <= loss_cnt_d;
    end
  end

  // Losing lock in MEASURE or LATCH abandons the window without publishing it.
  always_comb begin
    state_d    = state_q;
    gate_d     = gate_q;
    cnt_clr    = 1'b0;
    cnt_reload = 1'b0;
    cnt_en     = 1'b0;
    latch_now  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        gate_d  = '0;
        if (lk_s2_q) state_d = MEASURE;
      end
      MEASURE: begin
        if (!lk_s2_q) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          gate_d  = '0;
        end else begin
          cnt_en = 1'b1;
          if (gate_q == GATE_LAST) begin
            state_d = LATCH;
            gate_d  = '0;
          end else begin
            gate_d = gate_q + GATE_W'(1);
          end
        end
      end
      LATCH: begin
        gate_d = '0;
        if (!lk_s2_q) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          latch_now  = 1'b1;
          cnt_reload = 1'b1;
          state_d    = MEASURE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        gate_d  = '0;
      end
    endcase
  end

  always_comb begin
    valid_d      = latch_now;
    freq_count_d = latch_now ? counts : freq_count_q;
    freq_ok_d    = latch_now ? ok_now : freq_ok_q;
  end

  // A loss coinciding with CLEAR restarts the tally at one rather than zero.
  always_comb begin
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;
    if (lock_fall) begin
      lost_d     = 1'b1;
      loss_cnt_d = bus.CLEAR ? 8'd1 : 8'(sat_inc(32'(loss_cnt_q), 8));
    end else if (bus.CLEAR) begin
      lost_d     = 1'b0;
      loss_cnt_d = '0;
    end
  end

  assign bus.FREQ_COUNT    = freq_count_q;
  assign bus.FREQ_OK       = freq_ok_q;
  assign bus.VALID         = valid_q;
  assign bus.LOCK_LOST     = lost_q;
  assign bus.LOCK_LOSS_CNT = loss_cnt_q;

endmodule
